// File: rtl/sram_bank.sv
// sram_bank: small register-based storage bank with per-entry occupancy
// flags, a one-cycle registered read port, and a sweep engine that clears
// every entry, one per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepts one request per cycle: ClearAll > Clear > Load > RD
// SWEEP | zeroes one entry per cycle; all requests are ignored
module sram_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RD,
  input  logic              Load,
  input  logic              Clear,
  input  logic              ClearAll,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WIDTH-1:0]  dataIn,
  output logic [WIDTH-1:0]  dataOut,
  output logic              dataValid,
  output logic              busy,
  output logic              err,
  output logic [DEPTH-1:0]  led
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U    = 32'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              addr_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              led_val;
  logic              rd_en;
  logic              err_d;

  // Address range check; only meaningful when DEPTH is not a power of two.
  assign addr_ok = ({{(32-ADDR_W){1'b0}}, Address} < DEPTH_U);

  assign busy = (state_q == SWEEP);

  // Request arbitration, sweep sequencing and the single write port control.
  // The sweep shares the write port so an entry and its led bit clear together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = Address;
    wr_data = dataIn;
    led_val = 1'b0;
    rd_en   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ClearAll) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (Clear) begin
          if (addr_ok) begin
            wr_en   = 1'b1;
            wr_data = '0;
            led_val = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (Load) begin
          if (addr_ok) begin
            wr_en   = 1'b1;
            wr_data = dataIn;
            led_val = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (RD) begin
          if (addr_ok) begin
            rd_en = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        led_val = 1'b0;
        if (cnt_q == LAST_ENTRY) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array; not reset, stale contents are masked by led on read.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Occupancy flags follow every write to the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (wr_en) begin
      led[wr_addr] <= led_val;
    end
  end

  // Registered read data plus the one-cycle valid and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
      err       <= 1'b0;
    end else begin
      dataValid <= rd_en;
      err       <= err_d;
      if (rd_en) begin
        dataOut <= led[Address] ? mem[Address] : '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Testbench for sram_bank: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_sram_bank;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, ld = 1'b0, clr = 1'b0, ca = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] din = '0;

  logic [31:0] dout, dout6;
  logic        valid, busy, err, valid6, busy6, err6;
  logic [7:0]  led;
  logic [5:0]  led6;

  always #5 clk = ~clk;

  sram_bank #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) u_dut (
    .clk(clk), .rst(rst), .RD(rd), .Load(ld), .Clear(clr), .ClearAll(ca),
    .Address(addr), .dataIn(din), .dataOut(dout), .dataValid(valid),
    .busy(busy), .err(err), .led(led)
  );

  sram_bank #(.WIDTH(32), .DEPTH(6), .ADDR_W(3)) u_dut6 (
    .clk(clk), .rst(rst), .RD(rd), .Load(ld), .Clear(clr), .ClearAll(ca),
    .Address(addr), .dataIn(din), .dataOut(dout6), .dataValid(valid6),
    .busy(busy6), .err(err6), .led(led6)
  );

  // behavioural model of the depth-8 instance
  logic [31:0] m_mem [D];
  logic [7:0]  m_led = '0;
  logic [31:0] m_dout = '0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  int          m_sweep_left = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst, rd, ld, clr, ca;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] e_dout;
    bit          e_valid;
    logic [7:0]  e_led;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit i_rst, input bit i_rd, input bit i_ld, input bit i_clr,
                            input bit i_ca, input logic [2:0] i_addr, input logic [31:0] i_din);
    int a;
    a = int'(i_addr);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (i_rst) begin
      m_led = '0;
      m_dout = '0;
      m_sweep_left = 0;
    end else if (m_sweep_left > 0) begin
      m_mem[D - m_sweep_left] = '0;
      m_led[D - m_sweep_left] = 1'b0;
      m_sweep_left--;
    end else if (i_ca) begin
      m_sweep_left = D;
    end else if (i_clr) begin
      m_mem[a] = '0;
      m_led[a] = 1'b0;
    end else if (i_ld) begin
      m_mem[a] = i_din;
      m_led[a] = 1'b1;
    end else if (i_rd) begin
      m_dout  = m_led[a] ? m_mem[a] : 32'h0;
      m_valid = 1'b1;
    end
  endtask

  task automatic step(input bit i_rst, input bit i_rd, input bit i_ld, input bit i_clr,
                      input bit i_ca, input logic [2:0] i_addr, input logic [31:0] i_din);
    @(negedge clk);
    rst = i_rst; rd = i_rd; ld = i_ld; clr = i_clr; ca = i_ca; addr = i_addr; din = i_din;
    @(posedge clk);
    model_edge(i_rst, i_rd, i_ld, i_clr, i_ca, i_addr, i_din);
    #1;
    check("model dataOut", dout, m_dout);
    check("model dataValid", 32'(valid), 32'(m_valid));
    check("model busy", 32'(busy), 32'(m_sweep_left != 0));
    check("model err", 32'(err), 32'(m_err));
    check("model led", 32'(led), 32'(m_led));
  endtask

  function automatic vec_t mk(input bit r, input bit i_rd, input bit i_ld, input bit i_clr,
                              input logic [2:0] a, input logic [31:0] d,
                              input logic [31:0] edout, input bit ev, input logic [7:0] eled);
    vec_t v;
    v.rst = r; v.rd = i_rd; v.ld = i_ld; v.clr = i_clr; v.ca = 1'b0;
    v.addr = a; v.din = d; v.e_dout = edout; v.e_valid = ev; v.e_led = eled;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    for (int i = 0; i < D; i++) m_mem[i] = '0;

    // directed table: reset, fill, read back, clear one, load/read collision
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 1, 0, 3'(i), 32'(2 * i), 32'h0, 0, 8'((1 << (i + 1)) - 1)));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 0, 0, 3'(i), 32'h0, 32'(2 * i), 1, 8'hFF));
    vecs.push_back(mk(0, 0, 0, 1, 3'd3, 32'h0, 32'd14, 0, 8'hF7));
    vecs.push_back(mk(0, 1, 0, 0, 3'd3, 32'h0, 32'h0, 1, 8'hF7));
    vecs.push_back(mk(0, 1, 0, 0, 3'd4, 32'h0, 32'd8, 1, 8'hF7));
    vecs.push_back(mk(0, 1, 1, 0, 3'd2, 32'hA5, 32'd8, 0, 8'hF7));
    vecs.push_back(mk(0, 1, 0, 0, 3'd2, 32'h0, 32'hA5, 1, 8'hF7));
    vecs.push_back(mk(0, 0, 0, 0, 3'd0, 32'h0, 32'hA5, 0, 8'hF7));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].rd, vecs[k].ld, vecs[k].clr, vecs[k].ca, vecs[k].addr, vecs[k].din);
      check($sformatf("vec%0d dataOut", k), dout, vecs[k].e_dout);
      check($sformatf("vec%0d dataValid", k), 32'(valid), 32'(vecs[k].e_valid));
      check($sformatf("vec%0d led", k), 32'(led), 32'(vecs[k].e_led));
      check($sformatf("vec%0d err", k), 32'(err), 32'h0);
      check($sformatf("vec%0d busy", k), 32'(busy), 32'h0);
    end

    // depth-6 instance: out-of-range load and read are rejected with err
    step(0, 0, 1, 0, 0, 3'd7, 32'hDEAD_BEEF);
    check("d6 load7 err", 32'(err6), 32'h1);
    check("d6 load7 led", 32'(led6), 32'h37);
    check("d6 load7 valid", 32'(valid6), 32'h0);
    check("d6 load7 dout", dout6, 32'hA5);
    step(0, 0, 0, 0, 0, 3'd0, 32'h0);
    check("d6 err one cycle", 32'(err6), 32'h0);
    step(0, 1, 0, 0, 0, 3'd7, 32'h0);
    check("d6 rd7 err", 32'(err6), 32'h1);
    check("d6 rd7 valid", 32'(valid6), 32'h0);
    check("d6 rd7 dout", dout6, 32'hA5);
    step(0, 1, 0, 0, 0, 3'd5, 32'h0);
    check("d6 rd5 dout", dout6, 32'd10);
    check("d6 rd5 valid", 32'(valid6), 32'h1);

    // full sweep with loads attempted throughout
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 3'(i), 32'((i + 1) * 3));
    check("prefill led", 32'(led), 32'hFF);
    step(0, 0, 0, 0, 1, 3'd0, 32'h0);
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      step(0, 0, 1, 0, 0, 3'(nb % 8), 32'hFFFF);
    end
    check("sweep busy cycles", nb, 32'd8);
    check("sweep led cleared", 32'(led), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0, 3'(i), 32'h0);
      check($sformatf("post-sweep rd%0d", i), dout, 32'h0);
      check($sformatf("post-sweep valid%0d", i), 32'(valid), 32'h1);
    end

    // reset during the fourth sweep cycle, with a load presented alongside
    step(0, 0, 1, 0, 0, 3'd5, 32'h1234);
    step(0, 1, 0, 0, 0, 3'd5, 32'h0);
    check("pre-reset rd5", dout, 32'h1234);
    step(0, 0, 0, 0, 1, 3'd0, 32'h0);
    step(0, 0, 0, 0, 0, 3'd0, 32'h0);
    step(0, 0, 0, 0, 0, 3'd0, 32'h0);
    step(0, 0, 0, 0, 0, 3'd0, 32'h0);
    check("sweep still busy", 32'(busy), 32'h1);
    step(1, 0, 1, 0, 0, 3'd1, 32'h77);
    check("rst busy", 32'(busy), 32'h0);
    check("rst led", 32'(led), 32'h0);
    check("rst dout", dout, 32'h0);
    check("rst valid", 32'(valid), 32'h0);
    step(0, 0, 1, 0, 0, 3'd1, 32'h55);
    check("post-rst load led", 32'(led), 32'h02);
    step(0, 1, 0, 0, 0, 3'd1, 32'h0);
    check("post-rst rd1", dout, 32'h55);

    // ClearAll held high restarts the sweep after one idle cycle
    nb = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 0, 0, 1, 3'd0, 32'h0);
      if (busy) nb++;
      if (i == 8) check("held ClearAll gap", 32'(busy), 32'h0);
    end
    check("held ClearAll busy count", nb, 32'd16);

    // randomized traffic checked against the model
    step(1, 0, 0, 0, 0, 3'd0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
           3'($urandom_range(0, 7)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries.
REQ-003 SHALL have parameter ADDR_W, default 3, address width; 2**ADDR_W >= DEPTH is required.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port RD  input  1  read request.
REQ-007 SHALL have port Load  input  1  write request.
REQ-008 SHALL have port Clear  input  1  clear single entry at Address.
REQ-009 SHALL have port ClearAll  input  1  start clear sweep of all entries.
REQ-010 SHALL have port Address  input  ADDR_W  entry index for RD/Load/Clear.
REQ-011 SHALL have port dataIn  input  WIDTH  write data.
REQ-012 SHALL have port dataOut  output  WIDTH  registered read data.
REQ-013 SHALL have port dataValid  output  1  one-cycle pulse, dataOut updated by accepted read.
REQ-014 SHALL have port busy  output  1  high while clear sweep runs.
REQ-015 SHALL have port err  output  1  one-cycle pulse, request rejected for Address >= DEPTH.
REQ-016 SHALL have port led  output  DEPTH  per-entry occupancy; bit i = entry i loaded since last clear.

Function
REQ-017 SHALL accept at most one operation per cycle in IDLE, priority ClearAll > Clear > Load > RD; lower-priority requests that cycle are dropped, not queued.
REQ-018 Load SHALL write dataIn to entry Address and set led[Address] at the same edge.
REQ-019 Clear SHALL write zero to entry Address and clear led[Address].
REQ-020 RD SHALL give 1-cycle latency: request sampled at edge N, dataOut and dataValid=1 during the cycle after edge N.
REQ-021 A read of an entry with led bit 0 SHALL return all-zero data, regardless of stored contents.
REQ-022 dataOut SHALL hold its last read value until the next accepted RD; dataValid SHALL be 1 for exactly one cycle per accepted RD.
REQ-023 An RD/Load/Clear with Address >= DEPTH SHALL change no storage, led or dataOut, and SHALL pulse err for one cycle; dataValid stays 0.
REQ-024 FSM SHALL have two states, IDLE and SWEEP; reset state is IDLE.
REQ-025 ClearAll in IDLE SHALL enter SWEEP at the next edge with sweep counter 0; busy=1 from that edge.
REQ-026 In SWEEP, each cycle SHALL zero entry counter and clear led[counter], then increment the counter; after entry DEPTH-1 the FSM returns to IDLE, busy=0, for DEPTH busy cycles in total.
REQ-027 In SWEEP, RD, Load, Clear and ClearAll SHALL be ignored: no err, no dataValid, no storage change.
REQ-028 ClearAll SHALL be level-sampled in IDLE only; ClearAll held high after a sweep completes SHALL start a new sweep.

Reset
REQ-029 rst=1 at an edge SHALL force: state IDLE, sweep counter 0, led all 0, dataOut 0, dataValid 0, busy 0, err 0.
REQ-030 Reset SHALL take priority over every request, including mid-sweep; storage contents need not be cleared (REQ-021 masks them).
REQ-031 Requests presented in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-032 Load entries i=0..7 with 2*i, then RD i=0..7 -> dataOut=2*i one cycle after each RD, dataValid pulse each, led=8'hFF.
REQ-033 After REQ-032 fill, Clear address 3, then RD 3 -> dataOut=0, led=8'hF7; RD 4 still returns 8.
REQ-034 Load and RD together at address 2 with dataIn=32'hA5 -> write accepted, no dataValid; next RD 2 returns 32'hA5.
REQ-035 DEPTH=6, ADDR_W=3: Load address 7 -> err pulses once, led unchanged, no write.
REQ-036 Filled bank, pulse ClearAll -> busy=1 for exactly 8 cycles, Load during sweep ignored, led=0 after the sweep, all reads return 0.
REQ-037 Assert rst during the 4th sweep cycle -> next cycle busy=0, led=0, dataOut=0, IDLE; a following Load is accepted normally.
